// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART data types and default sizing for the RX/TX buffers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int RX_FIFO_DEPTH   = 16;
    localparam int ERR_COUNT_WIDTH = 8;

    typedef logic [UART_DATA_WIDTH-1:0] uart_byte_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Generic single-clock show-ahead FIFO; push while full is accepted
//            only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_lvl_w-1:0] r_level;
    logic               w_wr_en;
    logic               w_rd_en;

    assign full    = (r_level == c_lvl_w'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rd_data = r_mem[r_rptr];

    // When full, the write slot equals the head slot; a same-cycle pop has
    // already presented the old head combinationally, so overwriting is safe.
    assign w_wr_en = push && (!full || pop);
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive buffer: delayed byte capture into a show-ahead FIFO,
//            valid/ready output, sticky framing/overflow flags and counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH       = RX_FIFO_DEPTH,
    parameter int COUNT_WIDTH = ERR_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  uart_byte_t               rxData,
    input  logic                     rxDone,
    input  logic                     rxErr,
    output uart_byte_t               outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     frameErr,
    output logic                     overflow,
    output logic [COUNT_WIDTH-1:0]   frameErrCount,
    output logic [COUNT_WIDTH-1:0]   overflowCount,
    input  logic                     clearErr
);

    localparam logic [COUNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [COUNT_WIDTH-1:0] c_cnt_one = COUNT_WIDTH'(1);

    logic r_done_dly;
    logic w_push;
    logic w_pop;
    logic w_drop;
    logic w_empty;

    // The receiver's data is only stable the cycle after its done pulse.
    assign w_push   = r_done_dly;
    assign w_pop    = outValid && outReady;
    assign w_drop   = w_push && full && !w_pop;
    assign outValid = !w_empty;

    sync_fifo #(
        .WIDTH (UART_DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .wr_data (rxData),
        .pop     (w_pop),
        .rd_data (outData),
        .level   (level),
        .full    (full),
        .empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_dly <= 1'b0;
        end else begin
            r_done_dly <= rxDone;
        end
    end

    // A new event in the clearing cycle wins: flag stays set, count restarts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            frameErr      <= 1'b0;
            frameErrCount <= '0;
        end else if (rxErr) begin
            frameErr <= 1'b1;
            if (clearErr) begin
                frameErrCount <= c_cnt_one;
            end else if (frameErrCount != c_cnt_max) begin
                frameErrCount <= frameErrCount + c_cnt_one;
            end
        end else if (clearErr) begin
            frameErr      <= 1'b0;
            frameErrCount <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow      <= 1'b0;
            overflowCount <= '0;
        end else if (w_drop) begin
            overflow <= 1'b1;
            if (clearErr) begin
                overflowCount <= c_cnt_one;
            end else if (overflowCount != c_cnt_max) begin
                overflowCount <= overflowCount + c_cnt_one;
            end
        end else if (clearErr) begin
            overflow      <= 1'b0;
            overflowCount <= '0;
        end
    end

endmodule

`default_nettype wire
